// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shift_reg
//  Purpose  : WIDTH-bit universal shift register with hold, shift, rotate,
//             arithmetic shift, parallel load and clear, plus a burst engine
//             that repeats one captured operation a programmed number of times.
//  Options  : define USR_STATUS_EN to add the `zero` status output (q == 0).
//  Revision : 1.0 - initial release
// ============================================================================
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
`ifdef USR_STATUS_EN
   ,
   output logic             zero
`endif
);

   // Operation encodings
   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_LOAD = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   localparam logic [CNT_W-1:0] REM_ZERO = '0;
   localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [2:0]         mode_r_q, mode_r_d;
   logic               done_q, done_d;

   logic [2:0]         op_sel;
   logic [WIDTH-1:0]   op_res;

   // Select the operation in effect: the captured one during a burst,
   // otherwise the live mode input for single steps.
   always_comb begin
      op_sel = mode;
      if (state_q == S_RUN) begin
         op_sel = mode_r_q;
      end
   end

   // Compute the result of applying the selected operation to the register.
   always_comb begin
      op_res = q_q;
      unique case (op_sel)
         OP_HOLD: op_res = q_q;
         OP_SHR:  op_res = {sin_r, q_q[WIDTH-1:1]};
         OP_SHL:  op_res = {q_q[WIDTH-2:0], sin_l};
         OP_LOAD: op_res = d;
         OP_ROR:  op_res = {q_q[0], q_q[WIDTH-1:1]};
         OP_ROL:  op_res = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
         OP_ASR:  op_res = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
         OP_CLR:  op_res = '0;
         default: op_res = q_q;
      endcase
   end

   // Next-state logic: burst capture/countdown and single-step application.
   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      rem_d    = rem_q;
      mode_r_d = mode_r_q;
      done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // A zero-length burst request is ignored, so it must not
            // block a single step issued in the same cycle.
            if (start && (count != REM_ZERO)) begin
               state_d  = S_RUN;
               rem_d    = count;
               mode_r_d = mode;
            end else if (en) begin
               q_d = op_res;
            end
         end
         S_RUN: begin
            q_d   = op_res;
            rem_d = rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any burst without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         q_q      <= '0;
         rem_q    <= '0;
         mode_r_q <= OP_HOLD;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         rem_q    <= rem_d;
         mode_r_q <= mode_r_d;
         done_q   <= done_d;
      end
   end

   assign q      = q_q;
   assign sout_r = q_q[0];
   assign sout_l = q_q[WIDTH-1];
   assign busy   = (state_q == S_RUN);
   assign done   = done_q;

`ifdef USR_STATUS_EN
   assign zero = (q_q == '0);
`endif

endmodule
`default_nettype wire

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised WIDTH-bit universal shift register: the multi-bit successor of the single D flip-flop, adding hold, parallel load, logical/arithmetic shift, rotate and clear modes. It also supports an autonomous burst mode that applies one operation a programmed number of times. It is the shared storage/serialisation element for datapath and serial-link blocks in the sequential_logic library.

## Interface
Parameters:
- WIDTH, 8, register width; legal range WIDTH >= 2.
- CNT_W, 4, width of the burst count; maximum burst is 2^CNT_W - 1 operations.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  single-step enable; applies `mode` once (IDLE only).
- mode  input  3  operation select (see Operation).
- start  input  1  burst request (IDLE only).
- count  input  CNT_W  number of operations in the burst.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering the MSB on a right shift.
- sin_l  input  1  serial input entering the LSB on a left shift.
- q  output  WIDTH  register contents.
- sout_r  output  1  q[0], combinational.
- sout_l  output  1  q[WIDTH-1], combinational.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse after the final burst operation.

## Operation
- mode encoding:
  - 000 HOLD: q unchanged.
  - 001 SHR: q <= {sin_r, q[W-1:1]}.
  - 010 SHL: q <= {q[W-2:0], sin_l}.
  - 011 LOAD: q <= d.
  - 100 ROR: q <= {q[0], q[W-1:1]}.
  - 101 ROL: q <= {q[W-2:0], q[W-1]}.
  - 110 ASR: q <= {q[W-1], q[W-1:1]}.
  - 111 CLR: q <= 0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start=1 with count!=0: capture mode into mode_r and count into remaining; go to RUN. q is unchanged on this edge.
  - start has priority over en.
  - start=1 with count=0: ignored; no state change and no done pulse. If en=1 in the same cycle, the single step is still applied.
  - en=1 (start not taken): apply `mode` to q once.
  - en=0: hold.
- RUN:
  - Each edge applies mode_r to q and decrements remaining.
  - On the edge where remaining==1: go to IDLE and set done=1 for exactly one cycle.
  - en, start, mode and count are ignored.
  - d, sin_r and sin_l are sampled live on every RUN edge, so LOAD reloads the current d each cycle.
- busy = (state == RUN).

## Timing
- Reset (asynchronous, immediate): q=0, busy=0, done=0, state=IDLE, remaining=0, mode_r=000; zero=1 when configured.
- Single step: q updates on the first rising edge with en=1.
- Burst of N operations:
  - busy rises the edge after start is sampled and stays high for exactly N cycles.
  - q reflects k operations after the k-th RUN edge.
  - done is high in the cycle after the N-th operation, coincident with busy low.
  - A new start is accepted in that same cycle, so back-to-back bursts have a one-cycle gap.
- Reset asserted mid-burst aborts the burst: all state returns to reset values and no done pulse is produced.
- sout_r and sout_l follow q with no added latency.

## Configuration
- Macro USR_STATUS_EN.
  - Defined: adds output port `zero` (1 bit) = (q == 0), combinational from q; reset value 1.
  - Not defined: the `zero` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: start a burst (mode 001, count 5), pull rst_n low after 2 cycles -> q=0x00, busy=0, done never asserted; after release, no activity without en/start.
- Single step, WIDTH=8: LOAD d=0xA5 -> q=0xA5; ROR -> 0xD2; ROL -> 0xA5; CLR -> 0x00; HOLD with en=1 -> 0x00.
- Serial in: q=0x00, SHR with sin_r=1, three steps -> 0x80, 0xC0, 0xE0; then SHL with sin_l=0, one step -> 0xC0; sout_r/sout_l track q[0]/q[7] each step.
- Burst: q=0x81, start with mode=101, count=3 -> busy high 3 cycles, q = 0x03, 0x06, 0x0C; done one cycle after the third; en=1/start=1 pulsed during busy have no effect.
- Burst edges: q=0x80, ASR burst count=7 -> q=0xFF; start with count=0 -> busy stays 0, no done; back-to-back start in the done cycle is accepted.
- With USR_STATUS_EN: zero=1 after reset, 0 after LOAD 0x01, 1 after SHR with sin_r=0, 0 after LOAD 0x40, 1 after CLR.
